// File: rtl/card_pkg.sv
// Shared card encodings, seven-segment codes and scoring helpers for the
// baccarat datapath.
package card_pkg;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] ACE   = 4'd1;
  localparam logic [3:0] JACK  = 4'd11;
  localparam logic [3:0] QUEEN = 4'd12;
  localparam logic [3:0] KING  = 4'd13;

  // Active-low segment codes, bit order [6:0] = g f e d c b a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_JACK  = 7'b1100001;
  localparam logic [6:0] SEG_QUEEN = 7'b0011000;
  localparam logic [6:0] SEG_KING  = 7'b0001001;

  // Baccarat points: Ace..9 at face value, tens and court cards worth nothing.
  function automatic logic [3:0] card_points(input logic [3:0] card);
    if (card >= ACE && card <= 4'd9) return card;
    else                             return NONE;
  endfunction

  // Next dealer card in the 1..13 cycle; the step is folded into 0..12
  // first so any integer step stays inside the range.
  function automatic logic [3:0] advance_card(input logic [3:0] card, input int step);
    int n;
    n = ((int'(card) - 1 + (step % 13) + 13) % 13) + 1;
    return 4'(n);
  endfunction

endpackage

// File: rtl/card7seg.sv
// Card value to active-low seven-segment pattern; unused codes show blank.
module card7seg
  import card_pkg::*;
(
  input  logic [3:0] card,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default assigned before the case so no path can infer a latch.
    seg = SEG_BLANK;
    unique case (card)
      ACE:   seg = SEG_ACE;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = SEG_10;
      JACK:  seg = SEG_JACK;
      QUEEN: seg = SEG_QUEEN;
      KING:  seg = SEG_KING;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: free-running dealer counter, six load-enabled card
// registers, their displays and the two hand scores.
module baccarat_datapath
  import card_pkg::*;
#(
  parameter int CARD_STEP = 2
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard3_out,
  output logic [3:0] pscore_out,
  output logic [3:0] dscore_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  logic [3:0] new_card;
  logic [3:0] PReg1_out, PReg2_out, PReg3_out;
  logic [3:0] DReg1_out, DReg2_out, DReg3_out;
  logic [4:0] psum, dsum;

  // Every register with its strobe high takes the same card; the counter
  // moves on regardless of strobes.
  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // sample the pre-edge new_card.
      new_card  <= ACE;
      PReg1_out <= NONE;
      PReg2_out <= NONE;
      PReg3_out <= NONE;
      DReg1_out <= NONE;
      DReg2_out <= NONE;
      DReg3_out <= NONE;
    end else begin
      new_card <= advance_card(new_card, CARD_STEP);
      if (load_pcard1) PReg1_out <= new_card;
      if (load_pcard2) PReg2_out <= new_card;
      if (load_pcard3) PReg3_out <= new_card;
      if (load_dcard1) DReg1_out <= new_card;
      if (load_dcard2) DReg2_out <= new_card;
      if (load_dcard3) DReg3_out <= new_card;
    end
  end

  // Three cards of at most 9 points fit in 5 bits (max 27).
  always_comb begin
    psum = 5'(card_points(PReg1_out)) + 5'(card_points(PReg2_out))
         + 5'(card_points(PReg3_out));
    dsum = 5'(card_points(DReg1_out)) + 5'(card_points(DReg2_out))
         + 5'(card_points(DReg3_out));
  end

  assign pscore_out = 4'(psum % 5'd10);
  assign dscore_out = 4'(dsum % 5'd10);
  assign pcard3_out = PReg3_out;

  card7seg u_hex0 (.card(PReg1_out), .seg(HEX0));
  card7seg u_hex1 (.card(PReg2_out), .seg(HEX1));
  card7seg u_hex2 (.card(PReg3_out), .seg(HEX2));
  card7seg u_hex3 (.card(DReg1_out), .seg(HEX3));
  card7seg u_hex4 (.card(DReg2_out), .seg(HEX4));
  card7seg u_hex5 (.card(DReg3_out), .seg(HEX5));

endmodule

// File: tb/tb_baccarat_datapath.sv
// Scoreboard bench for baccarat_datapath: stimulus queues expected outputs,
// a monitor pops and compares them whenever a sample is requested.
module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b1;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  logic [3:0] pcard3_out, pscore_out, dscore_out;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  baccarat_datapath #(.CARD_STEP(2)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
    .pcard3_out (pcard3_out),
    .pscore_out (pscore_out),
    .dscore_out (dscore_out),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5)
  );

  always #5 slow_clock = ~slow_clock;

  // Display table, index = card code.
  logic [6:0] seg_tab [16] = '{
    7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
    7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111
  };

  typedef struct packed {
    logic [5:0][6:0] hex;   // [0..2] player 1..3, [3..5] dealer 1..3
    logic [3:0]      pscore;
    logic [3:0]      dscore;
    logic [3:0]      pcard3;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  event  sample_ev;
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t  e;
    string t;
    logic [6:0] hex_now [6];
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        hex_now = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
        for (int i = 0; i < 6; i++)
          check($sformatf("%s.HEX%0d", t, i), hex_now[i], e.hex[i]);
        check({t, ".pscore"}, 7'(pscore_out), 7'(e.pscore));
        check({t, ".dscore"}, 7'(dscore_out), 7'(e.dscore));
        check({t, ".pcard3"}, 7'(pcard3_out), 7'(e.pcard3));
      end
    end
  end

  task automatic push_exp(input string tag,
                          input logic [3:0] p1, p2, p3, d1, d2, d3,
                          input logic [3:0] ps, ds);
    exp_t e;
    e.hex[0] = seg_tab[p1];
    e.hex[1] = seg_tab[p2];
    e.hex[2] = seg_tab[p3];
    e.hex[3] = seg_tab[d1];
    e.hex[4] = seg_tab[d2];
    e.hex[5] = seg_tab[d3];
    e.pscore = ps;
    e.dscore = ds;
    e.pcard3 = p3;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    -> sample_ev;
  endtask

  // Strobe bits {d3,d2,d1,p3,p2,p1}; called at a falling edge, returns at the
  // next falling edge after queueing the expected register contents.
  task automatic deal(input string tag, input logic [5:0] ld,
                      input logic [3:0] p1, p2, p3, d1, d2, d3,
                      input logic [3:0] ps, ds);
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
    @(posedge slow_clock);
    #1;
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = '0;
    @(negedge slow_clock);
    push_exp(tag, p1, p2, p3, d1, d2, d3, ps, ds);
  endtask

  logic [3:0] sweep_vals [13] = '{4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd1, 4'd3,
                                  4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd2};

  initial begin
    // Reset held across two edges, with a strobe asserted that must be ignored.
    load_pcard1 = 1'b1;
    @(posedge slow_clock);
    @(posedge slow_clock);
    @(negedge slow_clock);
    push_exp("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    load_pcard1 = 1'b0;
    resetb      = 1'b0;

    // Dealing sequence 1,3,5,7,9,11 into P1,D1,P2,D2,P3,D3.
    deal("deal_p1", 6'b000001, 1, 0, 0, 0, 0, 0, 1, 0);
    deal("deal_d1", 6'b001000, 1, 0, 0, 3, 0, 0, 1, 3);
    deal("deal_p2", 6'b000010, 1, 5, 0, 3, 0, 0, 6, 3);
    deal("deal_d2", 6'b010000, 1, 5, 0, 3, 7, 0, 6, 0);
    deal("deal_p3", 6'b000100, 1, 5, 9, 3, 7, 0, 5, 0);
    deal("deal_d3", 6'b100000, 1, 5, 9, 3, 7, 11, 5, 0);
    // Idle edge burns card 13; registers hold.
    deal("idle",    6'b000000, 1, 5, 9, 3, 7, 11, 5, 0);
    // All six strobes together capture card 2: scores 6 and 6.
    deal("simul",   6'b111111, 2, 2, 2, 2, 2, 2, 6, 6);

    // Decoder sweep: all registers loaded each edge through the full cycle.
    for (int i = 0; i < 13; i++) begin
      logic [3:0] v, pts, sc;
      v   = sweep_vals[i];
      pts = (v <= 4'd9) ? v : 4'd0;
      sc  = 4'((3 * int'(pts)) % 10);
      deal($sformatf("sweep%0d", v), 6'b111111, v, v, v, v, v, v, sc, sc);
    end

    // Mid-game asynchronous reset between edges.
    #2 resetb = 1'b1;
    #1 push_exp("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge slow_clock);
    @(negedge slow_clock);
    push_exp("midreset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    resetb = 1'b0;

    // Counter restarts at 1, then 3.
    deal("post_reset_p1", 6'b000001, 1, 0, 0, 0, 0, 0, 1, 0);
    deal("post_reset_d1", 6'b001000, 1, 0, 0, 3, 0, 0, 1, 3);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
        @(negedge slow_clock);
        -> sample_ev;
        waited++;
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
